// File: rtl/tpu_seq.sv
// tpu_seq: compute sequencer for the systolic array and its A/B staging memories.
// After a start request it optionally clears the accumulator rows, then enables
// the array for the 3*DIM-2 cycles a DIM x DIM multiply needs, and ends with a
// one-cycle done pulse. hold freezes the sequence without losing any enabled cycle.
module tpu_seq #(
  parameter int DIM = 8,
  parameter int CW  = $clog2(3*DIM),
  parameter int RW  = $clog2(DIM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          acc,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          mem_en,
  output logic          sa_wren,
  output logic [RW-1:0] crow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(3*DIM-3);
  localparam logic [RW-1:0] ROW_LAST = RW'(DIM-1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] crow_q, crow_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mem_en_q, mem_en_d;
  logic          sa_wren_q, sa_wren_d;
  logic          advance;

  // Only a cycle that really wrote a row or enabled the array moves the sequence on
  always_comb begin
    advance = mem_en_q | sa_wren_q;
  end

  // State, position and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      crow_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_en_q  <= 1'b0;
      sa_wren_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crow_q    <= crow_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mem_en_q  <= mem_en_d;
      sa_wren_q <= sa_wren_d;
    end
  end

  // Next state, cycle counter and row index; steps only after an enabled cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crow_d  = crow_q;
    case (state_q)
      IDLE: begin
        if (start && !hold) begin
          state_d = acc ? RUN : CLEAR;
          cnt_d   = '0;
          crow_d  = '0;
        end
      end
      CLEAR: begin
        if (advance) begin
          if (crow_q == ROW_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            crow_d  = '0;
          end else begin
            crow_d = crow_q + RW'(1);
          end
        end
      end
      RUN: begin
        if (advance) begin
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode of the next state; hold sampled now gates the coming cycle's enables
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    sa_wren_d = (state_d == CLEAR) && !hold;
    mem_en_d  = (state_d == RUN) && !hold;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign mem_en  = mem_en_q;
  assign sa_wren = sa_wren_q;
  assign crow    = crow_q;

endmodule

// File: doc/tpu_seq.md
# tpu_seq

Compute sequencer that sits directly upstream of the systolic array and the A/B staging memories in the TPU. After a host start pulse it optionally zeroes the accumulator rows, then asserts the shared enable for exactly the number of cycles a DIM×DIM multiply needs. It finishes with a one-cycle done pulse. All outputs are registered state decodes; the block holds no datapath.

## Interface
- DIM, 8, matrix dimension; legal range 2–64
- CW, $clog2(3*DIM), width of the internal cycle counter
- RW, $clog2(DIM), width of the row index
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- acc  input  1  sampled together with start; 1 = keep existing C contents and skip the clear phase
- hold  input  1  freeze request, for example during a host bus access
- busy  output  1  high in CLEAR, RUN and DONE
- done  output  1  one-cycle pulse in DONE
- mem_en  output  1  enable to memA, memB and the systolic array
- sa_wren  output  1  systolic array C-row write enable; the host ties Cin to zero
- crow  output  RW  C row index written during CLEAR

## Operation
- States: IDLE, CLEAR, RUN, DONE, held in a 2-bit state register.
- IDLE
  - All outputs are 0.
  - start=1 with acc=0: go to CLEAR; crow=0.
  - start=1 with acc=1: go to RUN; counter=0.
- CLEAR
  - sa_wren=1 and crow equals the row index.
  - crow increments each non-held cycle.
  - After the cycle with crow=DIM-1: go to RUN, counter=0, crow=0.
- RUN
  - mem_en=1 for exactly 3*DIM-2 non-held cycles; the counter counts 0..3*DIM-3.
  - After the cycle with counter=3*DIM-3: go to DONE.
- DONE
  - done=1 for one cycle, then go to IDLE.
  - DONE is never held: hold is ignored in this state.
- hold=1 in CLEAR or RUN
  - State, counter and crow freeze.
  - mem_en=0 and sa_wren=0 in that cycle; busy stays 1 and crow keeps its value.
  - The run resumes exactly where it stopped, so total enabled cycles are unchanged.
- Ignored requests
  - start outside IDLE is ignored. It is not queued.
  - start in IDLE while hold=1 is ignored.
- Reset
  - rst_n low forces IDLE, with counter, crow and all outputs at 0.
  - This applies mid-run as well; no partial completion and no done pulse.
- Output timing: outputs are registered decodes of next-state, so each output reflects the current state in the same cycle.
- The counter never exceeds 3*DIM-3, and crow never exceeds DIM-1. Neither wraps.

## Timing
- Reset values: busy=0, done=0, mem_en=0, sa_wren=0, crow=0.
- Cycle numbering: start is sampled high at edge 0; cycle k is the cycle after edge k.
- acc=0, no hold:
  - CLEAR occupies cycles 1..DIM.
  - RUN occupies cycles DIM+1..4*DIM-2.
  - done=1 in cycle 4*DIM-1.
  - busy=0 from cycle 4*DIM.
- acc=1, no hold:
  - RUN occupies cycles 1..3*DIM-2.
  - done=1 in cycle 3*DIM-1.
- Each hold cycle in CLEAR or RUN delays every later event by exactly one cycle.
- Back-to-back:
  - Earliest accepted restart is start sampled at the IDLE edge following DONE.
  - Minimum start-to-start interval is 4*DIM cycles with acc=0, and 3*DIM with acc=1.

## Test plan
- Reset and idle (DIM=8): rst_n low, then released with start=0 → all outputs stay 0 for 50 cycles.
- Full run with clear (DIM=8, acc=0): start at edge 0 → the bench must check all of the following.
  - sa_wren=1 in cycles 1–8 with crow 0..7.
  - mem_en=1 in cycles 9–30, exactly 22 cycles.
  - done=1 only in cycle 31.
  - busy=1 in cycles 1–31.
- Accumulate run (DIM=8, acc=1): start at edge 0 → no sa_wren; mem_en in cycles 1–22; done in cycle 23.
- Hold mid-run (DIM=8, acc=0): hold=1 in cycles 4–5 and 15–17 → the bench must check all of the following.
  - crow stays at 3 during the hold.
  - mem_en is low in cycles 15–17.
  - Total mem_en cycles = 22 and total sa_wren cycles = 8.
  - done in cycle 36.
- Ignored starts:
  - start held high continuously → done pulses in cycles 31, 63, 95, …, giving a 32-cycle period.
  - start pulsed during RUN → no effect on timing.
- Reset mid-run: rst_n low in cycle 12 → the bench must check all of the following.
  - busy, mem_en and crow are 0 immediately, asynchronously.
  - No done pulse follows.
  - A new start after release produces the normal 31-cycle sequence.
